// File: rtl/cdma_rd_arb_pkg.sv
// Shared HBM/CDMA constants and the descriptor-slot state type used by the
// read-CDMA round-robin scheduler.
package iwTypes;

    localparam int HBM_ADDR_BITS       = 34;
    localparam int HBM_LEN_BITS        = 16;
    localparam int HBM_DATA_BITS       = 512;
    localparam int CDMA_RD_OUTSTANDING = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cdma_rd_arb_if.sv
// Bus bundle between requesters, the scheduler and the read CDMA engine.
// The scheduler takes the slave view; the surrounding system drives master.
interface cdma_rd_arb_if
    import iwTypes::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = HBM_ADDR_BITS,
    parameter int LEN_BITS  = HBM_LEN_BITS,
    parameter int DATA_BITS = HBM_DATA_BITS
);
    localparam int ID_BITS = $clog2(N_REQ);

    logic [N_REQ-1:0]                s_req_valid;
    logic [N_REQ-1:0]                s_req_ready;
    logic [N_REQ-1:0][ADDR_BITS-1:0] s_req_paddr;
    logic [N_REQ-1:0][LEN_BITS-1:0]  s_req_len;
    logic [N_REQ-1:0]                s_req_done;

    logic                 m_rd_valid;
    logic                 m_rd_ready;
    logic [ADDR_BITS-1:0] m_rd_paddr;
    logic [LEN_BITS-1:0]  m_rd_len;
    logic                 m_rd_done;

    logic                   s_data_tvalid;
    logic                   s_data_tready;
    logic [DATA_BITS-1:0]   s_data_tdata;
    logic [DATA_BITS/8-1:0] s_data_tkeep;
    logic                   s_data_tlast;

    logic                   m_data_tvalid;
    logic                   m_data_tready;
    logic [DATA_BITS-1:0]   m_data_tdata;
    logic [DATA_BITS/8-1:0] m_data_tkeep;
    logic                   m_data_tlast;
    logic [ID_BITS-1:0]     m_data_tdest;

    logic [1:0] err;

    modport slave (
        input  s_req_valid, s_req_paddr, s_req_len,
        output s_req_ready, s_req_done,
        output m_rd_valid, m_rd_paddr, m_rd_len,
        input  m_rd_ready, m_rd_done,
        input  s_data_tvalid, s_data_tdata, s_data_tkeep, s_data_tlast,
        output s_data_tready,
        output m_data_tvalid, m_data_tdata, m_data_tkeep, m_data_tlast, m_data_tdest,
        input  m_data_tready,
        output err
    );

    modport master (
        output s_req_valid, s_req_paddr, s_req_len,
        input  s_req_ready, s_req_done,
        input  m_rd_valid, m_rd_paddr, m_rd_len,
        output m_rd_ready, m_rd_done,
        output s_data_tvalid, s_data_tdata, s_data_tkeep, s_data_tlast,
        input  s_data_tready,
        input  m_data_tvalid, m_data_tdata, m_data_tkeep, m_data_tlast, m_data_tdest,
        output m_data_tready,
        input  err
    );

endinterface

// File: rtl/cdma_rd_arb_rr_id_fifo.sv
// Small synchronous FIFO holding requester IDs in issue order.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module rr_id_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the empty count already masks stale entries.
    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cdma_rd_arb.sv
// Round-robin scheduler sharing one read-CDMA engine among N_REQ requesters;
// routes returning data and completion pulses back by in-order ID FIFOs.
module cdma_rd_arb
    import iwTypes::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_BITS   = HBM_ADDR_BITS,
    parameter int LEN_BITS    = HBM_LEN_BITS,
    parameter int DATA_BITS   = HBM_DATA_BITS,
    parameter int OUTSTANDING = CDMA_RD_OUTSTANDING
) (
    input  logic         aclk,
    input  logic         aresetn,
    cdma_rd_arb_if.slave bus
);
    localparam int ID_BITS  = $clog2(N_REQ);
    localparam int CNT_BITS = $clog2(OUTSTANDING) + 1;
    localparam int DCNT_BITS = $clog2(2 * OUTSTANDING) + 1;
    localparam logic [CNT_BITS-1:0] CAP     = CNT_BITS'(OUTSTANDING);
    localparam logic [ID_BITS-1:0]  LAST_ID = ID_BITS'(N_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_BITS-1:0] paddr_q, paddr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [1:0]           err_q, err_d;

    logic [ID_BITS-1:0]   winner;
    logic                 any_req, slot_free, room, grant;
    logic                 data_pop, cfifo_pop;
    logic [ID_BITS-1:0]   dfifo_head, cfifo_head;
    logic                 dfifo_empty, dfifo_full, cfifo_empty, cfifo_full;
    logic [DCNT_BITS-1:0] dfifo_count;
    logic [CNT_BITS-1:0]  inflight;

    logic [DATA_BITS-1:0]   beat_data;
    logic [DATA_BITS/8-1:0] beat_keep;

    // First valid requester at or after rr_ptr, searching cyclically.
    always_comb begin
        logic [ID_BITS-1:0] idx;
        idx     = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_BITS'((int'(rr_ptr_q) + i) % N_REQ);
            if (!any_req && bus.s_req_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // A done arriving at capacity frees the room for a grant in the same cycle.
    assign cfifo_pop = bus.m_rd_done && !cfifo_empty;
    assign slot_free = (state_q == IDLE) || bus.m_rd_ready;
    assign room      = (inflight < CAP) || cfifo_pop;
    assign grant     = aresetn && slot_free && room && any_req;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        paddr_d  = paddr_q;
        len_d    = len_q;
        err_d    = err_q;
        done_d   = '0;
        unique case (state_q)
            IDLE: if (grant) state_d = HOLD;
            HOLD: begin
                if (grant)                state_d = HOLD;
                else if (bus.m_rd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            paddr_d  = bus.s_req_paddr[winner];
            len_d    = bus.s_req_len[winner];
            rr_ptr_d = (winner == LAST_ID) ? '0 : winner + 1'b1;
            if (bus.s_req_len[winner] == '0) err_d[0] = 1'b1;
        end
        if ((bus.s_data_tvalid && dfifo_empty) || (bus.m_rd_done && cfifo_empty))
            err_d[1] = 1'b1;
        if (cfifo_pop) done_d[cfifo_head] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            paddr_q  <= '0;
            len_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            paddr_q  <= paddr_d;
            len_q    <= len_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.s_req_ready = grant ? (N_REQ'(1) << winner) : '0;
    assign bus.s_req_done  = done_q;
    assign bus.m_rd_valid  = (state_q == HOLD);
    assign bus.m_rd_paddr  = paddr_q;
    assign bus.m_rd_len    = len_q;
    assign bus.err         = err_q;

    // Beats for the head descriptor pass straight through; empty dfifo stalls.
    assign beat_data          = aresetn ? bus.s_data_tdata : '0;
    assign beat_keep          = aresetn ? bus.s_data_tkeep : '0;
    assign bus.m_data_tdata   = beat_data;
    assign bus.m_data_tkeep   = beat_keep;
    assign bus.m_data_tlast   = aresetn && bus.s_data_tlast;
    assign bus.m_data_tdest   = aresetn ? dfifo_head : '0;
    assign bus.m_data_tvalid  = aresetn && bus.s_data_tvalid && !dfifo_empty;
    assign bus.s_data_tready  = aresetn && bus.m_data_tready && !dfifo_empty;
    assign data_pop = bus.m_data_tvalid && bus.m_data_tready && bus.s_data_tlast;

    // Data may trail its done pulse, so the data-routing FIFO gets extra depth.
    rr_id_fifo #(.DEPTH(2 * OUTSTANDING), .WIDTH(ID_BITS)) u_dfifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (grant),
        .push_data (winner),
        .pop       (data_pop),
        .pop_data  (dfifo_head),
        .empty     (dfifo_empty),
        .full      (dfifo_full),
        .count     (dfifo_count)
    );

    rr_id_fifo #(.DEPTH(OUTSTANDING), .WIDTH(ID_BITS)) u_cfifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (grant),
        .push_data (winner),
        .pop       (cfifo_pop),
        .pop_data  (cfifo_head),
        .empty     (cfifo_empty),
        .full      (cfifo_full),
        .count     (inflight)
    );

endmodule

// File: tb/tb_cdma_rd_arb.sv
// Self-checking bench for cdma_rd_arb: arbitration vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_cdma_rd_arb;
    import iwTypes::*;

    localparam int N   = 4;
    localparam int AB  = HBM_ADDR_BITS;
    localparam int LB  = HBM_LEN_BITS;
    localparam int DB  = HBM_DATA_BITS;
    localparam int OUT = CDMA_RD_OUTSTANDING;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    cdma_rd_arb_if #(.N_REQ(N), .ADDR_BITS(AB), .LEN_BITS(LB), .DATA_BITS(DB)) bus ();

    cdma_rd_arb #(
        .N_REQ(N), .ADDR_BITS(AB), .LEN_BITS(LB), .DATA_BITS(DB), .OUTSTANDING(OUT)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } arb_vec_t;

    arb_vec_t vec [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc_end();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_req_valid   = '0;
        bus.s_req_paddr   = '0;
        bus.s_req_len     = '0;
        bus.m_rd_ready    = 1'b0;
        bus.m_rd_done     = 1'b0;
        bus.s_data_tvalid = 1'b0;
        bus.s_data_tdata  = '0;
        bus.s_data_tkeep  = '0;
        bus.s_data_tlast  = 1'b0;
        bus.m_data_tready = 1'b0;
    endtask

    task automatic set_payloads();
        for (int i = 0; i < N; i++) begin
            bus.s_req_paddr[i] = AB'(32'h1000 * (i + 1));
            bus.s_req_len[i]   = LB'(16 * (i + 1));
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle_inputs();
        repeat (2) cyc_end();
        aresetn = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [63:0] exp_paddr(input int id);
        return 64'(32'h1000 * (id + 1));
    endfunction

    initial begin
        int grants;
        int order_err;
        int cnt [N];
        int exp_dest [4];
        bit exp_last [4];
        bit m_slot;
        logic [AB-1:0] m_paddr;
        logic [LB-1:0] m_len;
        int m_ptr;
        int q_data [$];
        int q_done [$];
        logic [N-1:0] exp_done_next;

        vec[0]  = '{4'b0000, 4'b0000};
        vec[1]  = '{4'b0001, 4'b0001};
        vec[2]  = '{4'b0001, 4'b0001};
        vec[3]  = '{4'b1010, 4'b0010};
        vec[4]  = '{4'b1010, 4'b1000};
        vec[5]  = '{4'b1111, 4'b0001};
        vec[6]  = '{4'b1100, 4'b0100};
        vec[7]  = '{4'b0110, 4'b0010};
        vec[8]  = '{4'b1001, 4'b1000};
        vec[9]  = '{4'b0100, 4'b0100};
        vec[10] = '{4'b0000, 4'b0000};
        vec[11] = '{4'b0000, 4'b0000};

        // ---------------- reset values, with inputs active during reset
        idle_inputs();
        bus.s_req_valid   = '1;
        bus.m_rd_ready    = 1'b1;
        bus.s_data_tvalid = 1'b1;
        bus.m_data_tready = 1'b1;
        set_payloads();
        repeat (2) cyc_end();
        @(negedge aclk);
        check("rst_m_rd_valid", 64'(bus.m_rd_valid), 64'd0);
        check("rst_m_rd_paddr", 64'(bus.m_rd_paddr), 64'd0);
        check("rst_m_rd_len", 64'(bus.m_rd_len), 64'd0);
        check("rst_s_req_done", 64'(bus.s_req_done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_s_req_ready", 64'(bus.s_req_ready), 64'd0);
        check("rst_m_data_tvalid", 64'(bus.m_data_tvalid), 64'd0);
        check("rst_s_data_tready", 64'(bus.s_data_tready), 64'd0);

        // ---------------- arbitration vector table
        do_reset();
        set_payloads();
        bus.m_rd_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.s_req_valid = vec[k].valid;
            @(negedge aclk);
            check($sformatf("tbl%0d_ready", k), 64'(bus.s_req_ready), 64'(vec[k].exp_ready));
            if (k > 0) begin
                check($sformatf("tbl%0d_mvalid", k), 64'(bus.m_rd_valid),
                      64'(vec[k-1].exp_ready != '0));
                if (vec[k-1].exp_ready != '0)
                    check($sformatf("tbl%0d_paddr", k), 64'(bus.m_rd_paddr),
                          exp_paddr(onehot_idx(vec[k-1].exp_ready)));
            end
            cyc_end();
        end

        // ---------------- single requester, 4-beat read
        do_reset();
        bus.s_req_valid    = 4'b0001;
        bus.s_req_paddr[0] = AB'(32'h1000);
        bus.s_req_len[0]   = LB'(256);
        @(negedge aclk);
        check("single_accept", 64'(bus.s_req_ready), 64'h1);
        check("single_mvalid_same_cycle", 64'(bus.m_rd_valid), 64'd0);
        cyc_end();
        bus.s_req_valid    = '0;
        bus.s_req_paddr[0] = AB'(32'hDEAD0);
        bus.s_req_len[0]   = LB'(7);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check($sformatf("single_hold%0d_valid", c), 64'(bus.m_rd_valid), 64'd1);
            check($sformatf("single_hold%0d_paddr", c), 64'(bus.m_rd_paddr), 64'h1000);
            check($sformatf("single_hold%0d_len", c), 64'(bus.m_rd_len), 64'd256);
            cyc_end();
        end
        bus.m_rd_ready = 1'b1;
        cyc_end();
        bus.m_rd_ready = 1'b0;
        @(negedge aclk);
        check("single_slot_released", 64'(bus.m_rd_valid), 64'd0);
        bus.m_data_tready = 1'b1;
        bus.s_data_tkeep  = '1;
        for (int b = 0; b < 4; b++) begin
            bus.s_data_tvalid = 1'b1;
            bus.s_data_tdata  = DB'(64'hA0 + 64'(b));
            bus.s_data_tlast  = (b == 3);
            @(negedge aclk);
            check($sformatf("single_beat%0d_tvalid", b), 64'(bus.m_data_tvalid), 64'd1);
            check($sformatf("single_beat%0d_tdest", b), 64'(bus.m_data_tdest), 64'd0);
            check($sformatf("single_beat%0d_tlast", b), 64'(bus.m_data_tlast), 64'(b == 3));
            check($sformatf("single_beat%0d_tdata", b), bus.m_data_tdata[63:0], 64'hA0 + 64'(b));
            check($sformatf("single_beat%0d_tready", b), 64'(bus.s_data_tready), 64'd1);
            cyc_end();
        end
        bus.s_data_tvalid = 1'b0;
        bus.s_data_tlast  = 1'b0;
        bus.m_rd_done     = 1'b1;
        @(negedge aclk);
        check("single_done_not_early", 64'(bus.s_req_done), 64'd0);
        cyc_end();
        bus.m_rd_done = 1'b0;
        @(negedge aclk);
        check("single_done_pulse", 64'(bus.s_req_done), 64'h1);
        cyc_end();
        @(negedge aclk);
        check("single_done_one_wide", 64'(bus.s_req_done), 64'd0);
        check("single_err", 64'(bus.err), 64'd0);

        // ---------------- fairness with all requesters valid
        do_reset();
        set_payloads();
        bus.s_req_valid = '1;
        bus.m_rd_ready  = 1'b1;
        order_err = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            bus.m_rd_done = (c > 0);
            @(negedge aclk);
            if (bus.s_req_ready != (4'b0001 << (c % N))) order_err++;
            for (int i = 0; i < N; i++) if (bus.s_req_ready[i]) cnt[i]++;
            cyc_end();
        end
        bus.m_rd_done = 1'b0;
        check("rr_order_errors", 64'(order_err), 64'd0);
        for (int i = 0; i < N; i++) check($sformatf("rr_share%0d", i), 64'(cnt[i]), 64'd25);

        // ---------------- requesters 2 then 1, routing and done order
        do_reset();
        set_payloads();
        bus.m_rd_ready  = 1'b1;
        bus.s_req_valid = 4'b0100;
        @(negedge aclk);
        check("two_grant_r2", 64'(bus.s_req_ready), 64'h4);
        cyc_end();
        bus.s_req_valid = 4'b0010;
        @(negedge aclk);
        check("two_grant_r1", 64'(bus.s_req_ready), 64'h2);
        cyc_end();
        bus.s_req_valid = '0;
        exp_dest = '{2, 2, 2, 1};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus.m_data_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.s_data_tvalid = 1'b1;
            bus.s_data_tlast  = exp_last[b];
            @(negedge aclk);
            check($sformatf("two_beat%0d_tvalid", b), 64'(bus.m_data_tvalid), 64'd1);
            check($sformatf("two_beat%0d_tdest", b), 64'(bus.m_data_tdest), 64'(exp_dest[b]));
            cyc_end();
        end
        bus.s_data_tvalid = 1'b0;
        bus.s_data_tlast  = 1'b0;
        bus.m_rd_done     = 1'b1;
        cyc_end();
        @(negedge aclk);
        check("two_done_first", 64'(bus.s_req_done), 64'h4);
        cyc_end();
        bus.m_rd_done = 1'b0;
        @(negedge aclk);
        check("two_done_second", 64'(bus.s_req_done), 64'h2);
        cyc_end();
        @(negedge aclk);
        check("two_done_idle", 64'(bus.s_req_done), 64'd0);

        // ---------------- outstanding limit
        do_reset();
        set_payloads();
        bus.s_req_valid = '1;
        bus.m_rd_ready  = 1'b1;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            grants += $countones(bus.s_req_ready);
            if (c == 19) check("cap_ready_blocked", 64'(bus.s_req_ready), 64'd0);
            cyc_end();
        end
        check("cap_grants", 64'(grants), 64'(OUT));
        bus.m_rd_done = 1'b1;
        @(negedge aclk);
        check("cap_done_releases_one", 64'(bus.s_req_ready), 64'h1);
        cyc_end();
        bus.m_rd_done = 1'b0;
        @(negedge aclk);
        check("cap_blocked_again", 64'(bus.s_req_ready), 64'd0);

        // ---------------- zero-length descriptor
        do_reset();
        bus.s_req_valid    = 4'b1000;
        bus.s_req_paddr[3] = AB'(32'h3000);
        bus.s_req_len[3]   = '0;
        @(negedge aclk);
        check("len0_accept", 64'(bus.s_req_ready), 64'h8);
        cyc_end();
        bus.s_req_valid = '0;
        @(negedge aclk);
        check("len0_forwarded", 64'(bus.m_rd_valid), 64'd1);
        check("len0_len", 64'(bus.m_rd_len), 64'd0);
        check("len0_paddr", 64'(bus.m_rd_paddr), 64'h3000);
        check("len0_err", 64'(bus.err), 64'h1);

        // ---------------- spurious done
        do_reset();
        bus.m_rd_done = 1'b1;
        cyc_end();
        bus.m_rd_done = 1'b0;
        @(negedge aclk);
        check("spur_done_err", 64'(bus.err), 64'h2);
        check("spur_done_no_pulse", 64'(bus.s_req_done), 64'd0);

        // ---------------- spurious data beat is stalled
        do_reset();
        bus.s_data_tvalid = 1'b1;
        bus.m_data_tready = 1'b1;
        @(negedge aclk);
        check("spur_data_tvalid", 64'(bus.m_data_tvalid), 64'd0);
        check("spur_data_tready", 64'(bus.s_data_tready), 64'd0);
        cyc_end();
        @(negedge aclk);
        check("spur_data_err", 64'(bus.err), 64'h2);
        check("spur_data_still_stalled", 64'(bus.s_data_tready), 64'd0);

        // ---------------- reset with 5 descriptors in flight
        do_reset();
        set_payloads();
        bus.s_req_valid = 4'b1110;
        bus.m_rd_ready  = 1'b1;
        grants = 0;
        for (int c = 0; c < 5; c++) begin
            bus.m_rd_done = (c == 4);
            @(negedge aclk);
            grants += $countones(bus.s_req_ready);
            cyc_end();
        end
        check("mid_inflight_grants", 64'(grants), 64'd5);
        aresetn           = 1'b0;
        bus.m_rd_done     = 1'b0;
        bus.s_data_tvalid = 1'b1;
        bus.m_data_tready = 1'b1;
        @(negedge aclk);
        check("mid_rst_ready_gated", 64'(bus.s_req_ready), 64'd0);
        cyc_end();
        @(negedge aclk);
        check("mid_rst_mvalid", 64'(bus.m_rd_valid), 64'd0);
        check("mid_rst_paddr", 64'(bus.m_rd_paddr), 64'd0);
        check("mid_rst_len", 64'(bus.m_rd_len), 64'd0);
        check("mid_rst_done", 64'(bus.s_req_done), 64'd0);
        check("mid_rst_err", 64'(bus.err), 64'd0);
        check("mid_rst_tvalid", 64'(bus.m_data_tvalid), 64'd0);
        cyc_end();
        aresetn           = 1'b1;
        bus.s_data_tvalid = 1'b0;
        bus.s_req_valid   = '1;
        @(negedge aclk);
        check("mid_fresh_grant", 64'(bus.s_req_ready), 64'h1);
        cyc_end();
        bus.s_req_valid = '0;
        @(negedge aclk);
        check("mid_fresh_mvalid", 64'(bus.m_rd_valid), 64'd1);
        check("mid_fresh_paddr", 64'(bus.m_rd_paddr), exp_paddr(0));
        cyc_end();
        bus.s_data_tvalid = 1'b1;
        bus.s_data_tlast  = 1'b1;
        @(negedge aclk);
        check("mid_fresh_tvalid", 64'(bus.m_data_tvalid), 64'd1);
        check("mid_fresh_tdest", 64'(bus.m_data_tdest), 64'd0);
        cyc_end();
        bus.s_data_tvalid = 1'b0;
        bus.s_data_tlast  = 1'b0;
        bus.m_rd_done     = 1'b1;
        cyc_end();
        bus.m_rd_done = 1'b0;
        @(negedge aclk);
        check("mid_fresh_done", 64'(bus.s_req_done), 64'h1);
        check("mid_fresh_err", 64'(bus.err), 64'd0);

        // ---------------- randomized run against the reference model
        do_reset();
        m_slot = 1'b0;
        m_paddr = '0;
        m_len = '0;
        m_ptr = 0;
        q_data.delete();
        q_done.delete();
        exp_done_next = '0;
        for (int c = 0; c < 600; c++) begin
            int win;
            bit free_slot;
            bit has_room;
            bit pop_done;
            logic [N-1:0] exp_ready;
            bus.s_req_valid = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                bus.s_req_paddr[i] = AB'({$urandom, $urandom});
                bus.s_req_len[i]   = LB'($urandom_range(1, 4096));
            end
            bus.m_rd_ready    = ($urandom_range(0, 3) != 0);
            bus.m_data_tready = 1'($urandom_range(0, 1));
            bus.m_rd_done     = (q_done.size() > q_data.size()) && ($urandom_range(0, 2) == 0);
            bus.s_data_tvalid = (q_data.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.s_data_tlast  = ($urandom_range(0, 2) == 0);
            bus.s_data_tdata  = DB'({$urandom, $urandom});

            pop_done  = bus.m_rd_done && (q_done.size() > 0);
            free_slot = !m_slot || bus.m_rd_ready;
            has_room  = (q_done.size() < OUT) || pop_done;
            win = -1;
            if (free_slot && has_room)
                for (int j = N - 1; j >= 0; j--)
                    if (bus.s_req_valid[(m_ptr + j) % N]) win = (m_ptr + j) % N;
            exp_ready = (win >= 0) ? (N'(1) << win) : '0;

            @(negedge aclk);
            check($sformatf("rnd%0d_ready", c), 64'(bus.s_req_ready), 64'(exp_ready));
            check($sformatf("rnd%0d_mvalid", c), 64'(bus.m_rd_valid), 64'(m_slot));
            if (m_slot) begin
                check($sformatf("rnd%0d_paddr", c), 64'(bus.m_rd_paddr), 64'(m_paddr));
                check($sformatf("rnd%0d_len", c), 64'(bus.m_rd_len), 64'(m_len));
            end
            check($sformatf("rnd%0d_tvalid", c), 64'(bus.m_data_tvalid),
                  64'(bus.s_data_tvalid && (q_data.size() > 0)));
            if (bus.s_data_tvalid && q_data.size() > 0)
                check($sformatf("rnd%0d_tdest", c), 64'(bus.m_data_tdest), 64'(q_data[0]));
            check($sformatf("rnd%0d_done", c), 64'(bus.s_req_done), 64'(exp_done_next));

            exp_done_next = pop_done ? (N'(1) << q_done.pop_front()) : '0;
            if (bus.s_data_tvalid && bus.m_data_tready && bus.s_data_tlast && q_data.size() > 0)
                void'(q_data.pop_front());
            if (win >= 0) begin
                m_slot  = 1'b1;
                m_paddr = bus.s_req_paddr[win];
                m_len   = bus.s_req_len[win];
                q_data.push_back(win);
                q_done.push_back(win);
                m_ptr = (win + 1) % N;
            end else if (bus.m_rd_ready) begin
                m_slot = 1'b0;
            end
            cyc_end();
        end
        idle_inputs();
        @(negedge aclk);
        check("rnd_err_clean", 64'(bus.err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
